// File: rtl/spc_stack.sv
// Subroutine PC stack: a registered top-of-stack over a DEPTH-entry memory, with
// push/pop/replace gated by state_fetch, a synchronous clear, and sticky overflow/underflow flags.
module spc_stack #(
    parameter int WIDTH      = 19,
    parameter int DEPTH_LOG2 = 5,
    parameter int WRAP       = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  state_fetch,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  clear,
    input  logic [WIDTH-1:0]      spcw,
    output logic [WIDTH-1:0]      spco,
    output logic [DEPTH_LOG2-1:0] spcptr,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  empty,
    output logic                  full,
    output logic                  ovf,
    output logic                  unf
);

    localparam int unsigned           DEPTH     = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LEVEL_MAX = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = (DEPTH_LOG2)'(1);
    localparam logic                  WRAPS     = (WRAP != 0);

    logic [WIDTH-1:0] mem [DEPTH];

    logic                  op_push;
    logic                  op_pop;
    logic                  op_repl;
    logic                  advance;
    logic                  retreat;
    logic                  overwrite;
    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] wr_addr;
    logic [DEPTH_LOG2-1:0] ptr_next;
    logic [DEPTH_LOG2:0]   level_next;

    always_comb begin
        op_push   = state_fetch & push & ~pop;
        op_pop    = state_fetch & pop & ~push;
        op_repl   = state_fetch & push & pop;
        // Replace on an empty stack behaves as a plain push.
        advance   = (op_push & (~full | WRAPS)) | (op_repl & empty);
        retreat   = op_pop & (~empty | WRAPS);
        overwrite = op_repl & ~empty;
        wr_en     = ~clear & (advance | overwrite);
        wr_addr   = advance ? spcptr + PTR_ONE : spcptr;

        ptr_next   = spcptr;
        level_next = level;
        if (clear) begin
            ptr_next   = '0;
            level_next = '0;
        end else if (advance) begin
            ptr_next = spcptr + PTR_ONE;
            if (!full) level_next = level + LEVEL_ONE;
        end else if (retreat) begin
            ptr_next = spcptr - PTR_ONE;
            if (!empty) level_next = level - LEVEL_ONE;
        end
    end

    // Memory is deliberately left out of reset and clear.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= spcw;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spcptr <= '0;
            level  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
            spco   <= '0;
        end else begin
            spcptr <= ptr_next;
            level  <= level_next;
            empty  <= (level_next == '0);
            full   <= (level_next == LEVEL_MAX);
            ovf    <= clear ? 1'b0 : (ovf | (op_push & full));
            unf    <= clear ? 1'b0 : (unf | (op_pop & empty));
            // Reading the pre-edge pointer gives one-cycle latency; forcing zero on either
            // side of an empty transition keeps stale memory off spco while empty.
            spco   <= (empty || level_next == '0) ? '0 : mem[spcptr];
        end
    end

endmodule

// File: tb/tb_spc_stack.sv
// Scoreboard bench for spc_stack: one bounded (WRAP=0) and one circular (WRAP=1) instance
// share stimulus and are checked against a stack model kept in plain arrays.
module tb_spc_stack;

    localparam int W  = 19;
    localparam int DL = 5;
    localparam int D  = 32;

    typedef struct {
        logic [W-1:0]  spco;
        logic [DL-1:0] ptr;
        logic [DL:0]   lvl;
        logic          empty;
        logic          full;
        logic          ovf;
        logic          unf;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic         state_fetch;
    logic         push;
    logic         pop;
    logic         clear;
    logic [W-1:0] spcw;

    logic [W-1:0]  spco0,  spco1;
    logic [DL-1:0] ptr0,   ptr1;
    logic [DL:0]   lvl0,   lvl1;
    logic          empty0, empty1, full0, full1, ovf0, ovf1, unf0, unf1;

    spc_stack #(.WIDTH(W), .DEPTH_LOG2(DL), .WRAP(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .state_fetch(state_fetch), .push(push), .pop(pop),
        .clear(clear), .spcw(spcw), .spco(spco0), .spcptr(ptr0), .level(lvl0),
        .empty(empty0), .full(full0), .ovf(ovf0), .unf(unf0)
    );

    spc_stack #(.WIDTH(W), .DEPTH_LOG2(DL), .WRAP(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .state_fetch(state_fetch), .push(push), .pop(pop),
        .clear(clear), .spcw(spcw), .spco(spco1), .spcptr(ptr1), .level(lvl1),
        .empty(empty1), .full(full1), .ovf(ovf1), .unf(unf1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    obs_t exp_q[$];

    // Reference stack: entries in an array, top index, count and error flags.
    logic [W-1:0] m_mem [2][D];
    int           m_ptr [2];
    int           m_lvl [2];
    bit           m_ovf [2];
    bit           m_unf [2];

    task automatic cmp(input string name, input int w, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s wrap=%0d t=%0t: got %h, expected %h", name, w, $time, act, exp);
        end
    endtask

    function automatic obs_t get_obs(input int w);
        obs_t o;
        if (w == 0) begin
            o.spco = spco0; o.ptr = ptr0; o.lvl = lvl0; o.empty = empty0;
            o.full = full0; o.ovf = ovf0; o.unf = unf0;
        end else begin
            o.spco = spco1; o.ptr = ptr1; o.lvl = lvl1; o.empty = empty1;
            o.full = full1; o.ovf = ovf1; o.unf = unf1;
        end
        return o;
    endfunction

    task automatic check_obs(input int w, input obs_t a, input obs_t e);
        cmp("spco",   w, 32'(a.spco),  32'(e.spco));
        cmp("spcptr", w, 32'(a.ptr),   32'(e.ptr));
        cmp("level",  w, 32'(a.lvl),   32'(e.lvl));
        cmp("empty",  w, 32'(a.empty), 32'(e.empty));
        cmp("full",   w, 32'(a.full),  32'(e.full));
        cmp("ovf",    w, 32'(a.ovf),   32'(e.ovf));
        cmp("unf",    w, 32'(a.unf),   32'(e.unf));
    endtask

    function automatic void model_reset();
        for (int w = 0; w < 2; w++) begin
            m_ptr[w] = 0; m_lvl[w] = 0; m_ovf[w] = 0; m_unf[w] = 0;
        end
    endfunction

    function automatic obs_t model_step(input int w, input bit sf, input bit pu, input bit po,
                                        input bit cl, input logic [W-1:0] d);
        obs_t         o;
        bit           wrap      = (w == 1);
        bit           was_empty = (m_lvl[w] == 0);
        logic [W-1:0] old_top   = m_mem[w][m_ptr[w]];
        if (cl) begin
            m_ptr[w] = 0; m_lvl[w] = 0; m_ovf[w] = 0; m_unf[w] = 0;
        end else if (sf && pu && po && m_lvl[w] > 0) begin
            m_mem[w][m_ptr[w]] = d;
        end else if (sf && pu) begin
            if (m_lvl[w] == D) m_ovf[w] = 1;
            if (m_lvl[w] < D || wrap) begin
                m_ptr[w] = (m_ptr[w] + 1) % D;
                m_mem[w][m_ptr[w]] = d;
                if (m_lvl[w] < D) m_lvl[w]++;
            end
        end else if (sf && po) begin
            if (m_lvl[w] == 0) m_unf[w] = 1;
            if (m_lvl[w] > 0 || wrap) begin
                m_ptr[w] = (m_ptr[w] + D - 1) % D;
                if (m_lvl[w] > 0) m_lvl[w]--;
            end
        end
        // Top shows up one edge late and reads as zero around any empty state.
        o.spco  = (was_empty || m_lvl[w] == 0) ? '0 : old_top;
        o.ptr   = DL'(m_ptr[w]);
        o.lvl   = (DL + 1)'(m_lvl[w]);
        o.empty = (m_lvl[w] == 0);
        o.full  = (m_lvl[w] == D);
        o.ovf   = m_ovf[w];
        o.unf   = m_unf[w];
        return o;
    endfunction

    task automatic apply(input bit sf, input bit pu, input bit po, input bit cl, input logic [W-1:0] d);
        state_fetch = sf; push = pu; pop = po; clear = cl; spcw = d;
        for (int w = 0; w < 2; w++) exp_q.push_back(model_step(w, sf, pu, po, cl, d));
    endtask

    task automatic cycle(input bit sf, input bit pu, input bit po, input bit cl, input logic [W-1:0] d);
        @(negedge clk);
        #1;
        apply(sf, pu, po, cl, d);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    // Monitor: every output cycle pops the expected state of both instances.
    initial begin
        obs_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() >= 2) begin
                e = exp_q.pop_front();
                check_obs(0, get_obs(0), e);
                e = exp_q.pop_front();
                check_obs(1, get_obs(1), e);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        for (int w = 0; w < 2; w++) begin
            obs_t a = get_obs(w);
            cmp({tag, "_spco"},   w, 32'(a.spco),  32'h0);
            cmp({tag, "_spcptr"}, w, 32'(a.ptr),   32'h0);
            cmp({tag, "_level"},  w, 32'(a.lvl),   32'h0);
            cmp({tag, "_empty"},  w, 32'(a.empty), 32'h1);
            cmp({tag, "_flags"},  w, {29'd0, a.full, a.ovf, a.unf}, 32'h0);
        end
    endtask

    initial begin
        reset_n = 1'b1; state_fetch = 1'b0; push = 1'b0; pop = 1'b0; clear = 1'b0; spcw = '0;
        #1 reset_n = 1'b0;
        #1 check_reset_outputs("reset");
        model_reset();
        @(negedge clk);
        #1 reset_n = 1'b1;

        // Three pushes, settle, absolute check, three pops.
        for (int i = 1; i <= 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, W'(i));
        idle();
        @(negedge clk);
        #2;
        cmp("push3_spco",  0, 32'(spco0), 32'h3);
        cmp("push3_ptr",   0, 32'(ptr0),  32'd3);
        cmp("push3_level", 0, 32'(lvl0),  32'd3);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);
        idle();
        idle();

        // Fill past capacity, then drain fully.
        cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
        for (int i = 1; i <= 33; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, W'(i));
        idle();
        idle();
        for (int i = 0; i < 33; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);
        idle();

        // Replace at full width, pop to empty and beyond, push without strobe.
        cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 19'h7FFFF);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 19'h12345);
        idle();
        cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);
        idle();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 19'h0ABCD);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 19'h05555);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 19'h06666);
        idle();

        // Asynchronous reset mid-sequence, with an op on the first edge after release.
        @(negedge clk);
        #1;
        state_fetch = 1'b0; push = 1'b0; pop = 1'b0; clear = 1'b0;
        reset_n = 1'b0;
        #1 check_reset_outputs("midreset");
        model_reset();
        @(negedge clk);
        #1 reset_n = 1'b1;
        apply(1'b1, 1'b1, 1'b0, 1'b0, 19'h00042);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 19'h00077);
        idle();

        // Randomized phases biased toward growth, shrinkage and balance.
        for (int ph = 0; ph < 12; ph++) begin
            int unsigned pct = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 15 : 50;
            for (int i = 0; i < 150; i++) begin
                bit sf = ($urandom_range(0, 9) != 0);
                bit cl = ($urandom_range(0, 199) == 0);
                int unsigned r = $urandom_range(0, 99);
                bit pu = (r < pct);
                bit po = !pu || ($urandom_range(0, 7) == 0);
                cycle(sf, pu, po, cl, W'($urandom));
            end
        end
        idle();

        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spc_stack.md
SPC_STACK -- requirements
Module: spc_stack

Interface
REQ-001: Parameter WIDTH, default 19, entry width in bits.
REQ-002: Parameter DEPTH_LOG2, default 5, stack depth is 2**DEPTH_LOG2 entries.
REQ-003: Parameter WRAP, default 0; 1 = circular pointer (original SPC behaviour), 0 = bounded stack with full/empty protection.
REQ-004: clk  input  1  single clock; all state updates on its rising edge.
REQ-005: reset_n  input  1  asynchronous, active-low reset.
REQ-006: state_fetch  input  1  operation strobe; push/pop take effect only in a cycle with state_fetch=1.
REQ-007: push  input  1  push request.
REQ-008: pop  input  1  pop request.
REQ-009: clear  input  1  synchronous flush, independent of state_fetch.
REQ-010: spcw  input  WIDTH  data to push.
REQ-011: spco  output  WIDTH  registered top-of-stack.
REQ-012: spcptr  output  DEPTH_LOG2  index of the current top entry.
REQ-013: level  output  DEPTH_LOG2+1  number of valid entries.
REQ-014: empty, full  output  1 each  level==0 / level==2**DEPTH_LOG2; both driven from registered state.
REQ-015: ovf, unf  output  1 each  sticky overflow / underflow error flags.

Function
REQ-016: The block SHALL define an operation as valid only in a cycle with state_fetch=1; push/pop with state_fetch=0 SHALL change no state.
REQ-017: A push alone SHALL increment spcptr modulo 2**DEPTH_LOG2, write spcw at the new pointer and increment level.
REQ-018: A pop alone SHALL decrement spcptr modulo 2**DEPTH_LOG2 and decrement level; the popped value is spco as held before the pop.
REQ-019: Push and pop together (replace) SHALL overwrite the entry at spcptr with spcw and leave spcptr and level unchanged; replace on empty SHALL behave as a push.
REQ-020: spco SHALL equal the entry at spcptr, updated one clock after the operation edge (latency 1); a value pushed at edge N SHALL appear on spco after edge N+1, with no stale-data read-during-write hazard.
REQ-021: When empty=1, spco SHALL hold all zeros.
REQ-022: WRAP=0, push alone while full: push SHALL be ignored (no write, no pointer move) and ovf SHALL set.
REQ-023: WRAP=0, pop alone while empty: pop SHALL be ignored and unf SHALL set.
REQ-024: WRAP=1: pointer SHALL wrap silently, overwriting the oldest entry; level SHALL saturate at 2**DEPTH_LOG2 and floor at 0; ovf/unf SHALL set on the same conditions as WRAP=0, but the operation SHALL still execute.
REQ-025: clear SHALL set spcptr, level, empty=1, full=0 and spco=0, and SHALL also clear ovf/unf; clear SHALL take priority over any simultaneous operation.
REQ-026: ovf/unf SHALL remain set until clear or reset.
REQ-027: Memory content SHALL be preserved across clear; only pointer and flag state is reset.

Reset
REQ-028: While reset_n=0 the block SHALL asynchronously force spcptr=0, level=0, spco=0, empty=1, full=0, ovf=0, unf=0.
REQ-029: Deassertion of reset_n SHALL be synchronised externally; the first operation SHALL be accepted on the first rising edge with reset_n=1.
REQ-030: Memory contents SHALL NOT be required to reset.

Verification
REQ-031: Defaults: push 0x00001..0x00003 -> spco = 0x00003, spcptr = 3, level = 3; three pops -> spco 0x00002, 0x00001, then 0 with empty=1.
REQ-032: WRAP=0: push 33 times -> 33rd ignored, full=1, ovf=1, level=32; the top still equals the 32nd value.
REQ-033: WRAP=1: push 33 values -> spcptr=1, level=32, ovf=1; 32 pops return values 33 down to 2.
REQ-034: Push 0x7FFFF, then replace with 0x12345 -> spco=0x12345, level unchanged; pop on empty with WRAP=0 -> unf=1, level=0.
REQ-035: Push with state_fetch=0 -> no change; assert reset_n=0 mid-sequence -> all outputs zero and empty=1 immediately, without waiting for a clock edge.
REQ-036: Simultaneous clear and push -> level=0, empty=1, ovf=unf=0 after the edge.
